// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: holds the PC, drives the instruction-memory address,
// selects the next PC from the decoder's jr/jp/br, detects jump-to-self halts and counts retired instructions.
//
// state   | meaning
// BUBBLE  | first cycle after reset, covers synchronous ROM latency; no valid instruction
// RUN     | instruction at imem_addr is valid and the PC advances unless stalled
// HALT    | jump-to-self seen; processor frozen until reset
module fetch_pc_unit #(
    parameter int          PC_W     = 12,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            br,
    input  logic            jp,
    input  logic            jr,
    input  logic [31:0]     imm,
    input  logic [26:0]     target,
    input  logic [31:0]     rd_val,
    output logic [PC_W-1:0] imem_addr,
    output logic [31:0]     pc_out,
    output logic [31:0]     pc_plus1,
    output logic            insn_valid,
    output logic            halted,
    output logic [31:0]     retired
);

    typedef enum logic [1:0] {
        S_BUBBLE = 2'd0,
        S_RUN    = 2'd1,
        S_HALT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;
    logic        redirect;

    assign pc_plus1  = pc_q + 32'd1;
    assign pc_out    = pc_q;
    assign imem_addr = pc_q[PC_W-1:0];
    assign retired   = retired_q;
    assign redirect  = jr | jp | br;

    // jr beats jp beats br; the sequential +1 path can never equal pc_q
    always_comb begin
        next_pc = pc_plus1;
        if (jr) begin
            next_pc = rd_val;
        end else if (jp) begin
            next_pc = {5'b0, target};
        end else if (br) begin
            next_pc = pc_plus1 + imm;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        insn_valid = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_BUBBLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                insn_valid = 1'b1;
                if (!stall) begin
                    pc_d = next_pc;
                    if (retired_q != 32'hFFFF_FFFF) begin
                        retired_d = retired_q + 32'd1;
                    end
                    if (redirect && (next_pc == pc_q)) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_BUBBLE;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

endmodule
